snes_multi_ctrl: RTL

Parametrised multi-player SNES controller reader, the successor to the single-pad `snes_controller` inside the IO subsystem. It drives one shared latch/clock pair to up to `NUM_PLAYERS` pads and captures one serial data line per pad. Polls run on a free-running timer or on request. Per poll it publishes debounce-free button state, per-button press pulses and a pad-present flag for each player.

---
 rtl/snes_pkg.sv | 39 +++
 rtl/snes_rx_lane.sv | 57 +++++
 rtl/snes_multi_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/snes_pkg.sv
// snes_pkg: shared types and constants for the multi-player SNES pad reader.
//   snes_state_t : poll FSM states
//   snes_btn_t   : one pad's 16-bit button word (bit index = shift order)
//   BTN_*        : button indices within snes_btn_t
//   SNES_ID_MASK : the four trailing ID bits; a standard pad drives them high
package snes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } snes_state_t;

  typedef logic [15:0] snes_btn_t;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  localparam snes_btn_t SNES_ID_MASK = 16'hF000;

  // A pad is considered plugged in when all ID bits read back high; an
  // unplugged line floats/pulls low and fails this check.
  function automatic logic snes_id_ok(input snes_btn_t raw);
    return (raw & SNES_ID_MASK) == SNES_ID_MASK;
  endfunction

endpackage

// File: rtl/snes_rx_lane.sv
// snes_rx_lane: per-player receive path.
//   clk, rst : system clock, synchronous active-high reset
//   serial   : raw asynchronous pad data line
//   sample   : shift the synchronised data bit into the raw word
//   commit   : publish raw word (end of poll)
//   state    : registered button state, 1 = pressed
//   pressed  : one-cycle 0->1 edge pulses, valid only the cycle after commit
//   present  : pad detected on the last committed poll
module snes_rx_lane
  import snes_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      serial,
  input  logic      sample,
  input  logic      commit,
  output snes_btn_t state,
  output snes_btn_t pressed,
  output logic      present
);

  logic [1:0] sync;
  snes_btn_t  raw;
  snes_btn_t  btn_new;
  logic       pres_c;

  // Sync flops reset high so a reset-time read looks like "no buttons".
  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], serial};
  end

  // Bits arrive B first; shifting in from the top leaves bit 0 = B after 16.
  always_ff @(posedge clk) begin
    if (rst)         raw <= '0;
    else if (sample) raw <= {sync[1], raw[15:1]};
  end

  assign pres_c  = snes_id_ok(raw);
  assign btn_new = pres_c ? ~raw : '0;   // pad lines are active low

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= '0;
      pressed <= '0;
      present <= 1'b0;
    end else begin
      pressed <= '0;
      if (commit) begin
        state   <= btn_new;
        pressed <= btn_new & ~state;
        present <= pres_c;
      end
    end
  end

endmodule

// File: rtl/snes_multi_ctrl.sv
// snes_multi_ctrl: multi-player SNES controller reader sharing one latch/clock.
//   clk, rst    : system clock, synchronous active-high reset
//   con_serial  : per-player raw pad data (asynchronous)
//   poll_req    : single-cycle poll request (ignored while busy)
//   con_clock   : shared pad clock, idles high
//   con_latch   : shared pad latch, idles low
//   con_state   : per-player button state, 1 = pressed
//   con_pressed : per-player press pulses, coincident with con_valid
//   con_present : per-player pad-detected flag
//   con_valid   : one-cycle pulse when outputs update
//   busy        : high from LATCH entry through DONE
module snes_multi_ctrl
  import snes_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int CLK_DIV     = 300,
  parameter int POLL_CYCLES = 833333
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PLAYERS-1:0]            con_serial,
  input  logic                              poll_req,
  output logic                              con_clock,
  output logic                              con_latch,
  output logic [NUM_PLAYERS-1:0][15:0]      con_state,
  output logic [NUM_PLAYERS-1:0][15:0]      con_pressed,
  output logic [NUM_PLAYERS-1:0]            con_present,
  output logic                              con_valid,
  output logic                              busy
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int TW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

  snes_state_t state, state_nxt;
  logic [PW-1:0] phase;
  logic [3:0]    bit_cnt;
  logic          pending;
  logic          tmr_wrap;
  logic          phase_last;
  logic          start;
  logic          sample;
  logic          commit;

  // LATCH lasts two half periods, every other timed state one.
  assign phase_last = (state == ST_LATCH) ? (phase == PW'(2 * CLK_DIV - 1))
                                          : (phase == PW'(CLK_DIV - 1));

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      ST_IDLE: if (poll_req || pending) begin
        state_nxt = ST_LATCH;
        start     = 1'b1;
      end
      ST_LATCH: if (phase_last) state_nxt = ST_LOW;
      ST_LOW:   if (phase_last) state_nxt = ST_HIGH;
      ST_HIGH:  if (phase_last) state_nxt = (bit_cnt == 4'd15) ? ST_DONE : ST_LOW;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Phase restarts on every state change so each state sees 0..N-1.
  always_ff @(posedge clk) begin
    if (rst)                                           phase <= '0;
    else if (state_nxt != state || state == ST_IDLE)   phase <= '0;
    else                                               phase <= phase + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                                bit_cnt <= '0;
    else if (state == ST_LATCH)             bit_cnt <= '0;
    else if (state == ST_HIGH && phase_last) bit_cnt <= bit_cnt + 1'b1;
  end

  // Free-running poll timer; absent entirely when POLL_CYCLES is 0.
  if (POLL_CYCLES > 0) begin : g_tmr
    logic [TW-1:0] tmr;
    assign tmr_wrap = (tmr == TW'(POLL_CYCLES - 1));
    always_ff @(posedge clk) begin
      if (rst)           tmr <= '0;
      else if (tmr_wrap) tmr <= '0;
      else               tmr <= tmr + 1'b1;
    end
  end else begin : g_no_tmr
    assign tmr_wrap = 1'b0;
  end

  // One-deep: an expiry coinciding with the poll start is served by that poll.
  always_ff @(posedge clk) begin
    if (rst)           pending <= 1'b0;
    else if (start)    pending <= 1'b0;
    else if (tmr_wrap) pending <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      con_clock <= 1'b1;
      con_latch <= 1'b0;
      con_valid <= 1'b0;
    end else begin
      con_clock <= (state != ST_LOW);
      con_latch <= (state == ST_LATCH);
      con_valid <= commit;
    end
  end

  assign busy   = (state != ST_IDLE);
  assign sample = (state == ST_LOW) && phase_last;
  assign commit = (state == ST_DONE);

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_lane
    snes_rx_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .serial  (con_serial[p]),
      .sample  (sample),
      .commit  (commit),
      .state   (con_state[p]),
      .pressed (con_pressed[p]),
      .present (con_present[p])
    );
  end

endmodule
